// File: rtl/fhe_pkg.sv
// Shared constants and types for the FHE encryption datapath.
package fhe_pkg;

    localparam int unsigned FHE_N   = 256;
    localparam int unsigned FHE_ETA = 2;
    localparam int unsigned FHE_Q   = 7681;
    localparam int unsigned FHE_QW  = 13;

    // Number of CBD slices carried by one 16-bit random word.
    function automatic int unsigned slices_per_word(input int unsigned eta);
        return 16 / (2 * eta);
    endfunction

    localparam int unsigned SLICES_PER_WORD = slices_per_word(FHE_ETA);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        FIN   = 2'd3
    } cbd_state_e;

endpackage

// File: rtl/cbd_noise_sampler_if.sv
// Random-word input, coefficient output and control/status of the CBD sampler.
interface cbd_noise_sampler_if
    import fhe_pkg::*;
#(
    parameter int unsigned QW = FHE_QW,
    parameter int unsigned IW = $clog2(FHE_N)
);
    logic          start;
    logic          rng_valid;
    logic [15:0]   rng_word;
    logic          rng_ready;
    logic          coef_valid;
    logic          coef_ready;
    logic [QW-1:0] coef;
    logic [IW-1:0] coef_idx;
    logic          coef_last;
    logic          busy;
    logic          done;

    // Sampler side.
    modport master (
        input  start, rng_valid, rng_word, coef_ready,
        output rng_ready, coef_valid, coef, coef_idx, coef_last, busy, done
    );

    // Environment side (PRNG, NTT input buffer, controller).
    modport slave (
        output start, rng_valid, rng_word, coef_ready,
        input  rng_ready, coef_valid, coef, coef_idx, coef_last, busy, done
    );
endinterface

// File: rtl/cbd_map.sv
// Maps one 2*ETA-bit random slice to a centered-binomial coefficient mod Q.
module cbd_map #(
    parameter int unsigned ETA = 2,
    parameter int unsigned Q   = 7681,
    parameter int unsigned QW  = 13
) (
    input  logic [2*ETA-1:0] slice,
    output logic [QW-1:0]    coef
);
    localparam int unsigned PW = $clog2(ETA + 1);

    logic [PW-1:0] pop_a;
    logic [PW-1:0] pop_b;

    // Popcount of each half, then fold a negative difference up by Q.
    always_comb begin
        pop_a = '0;
        pop_b = '0;
        for (int i = 0; i < ETA; i++) begin
            pop_a = pop_a + PW'(slice[i]);
            pop_b = pop_b + PW'(slice[ETA + i]);
        end
        if (pop_a >= pop_b) begin
            coef = QW'(pop_a - pop_b);
        end else begin
            coef = QW'(Q) - QW'(pop_b - pop_a);
        end
    end
endmodule

// File: rtl/cbd_noise_sampler.sv
// Turns 16-bit PRNG words into one polynomial of CBD error coefficients mod Q.
module cbd_noise_sampler
    import fhe_pkg::*;
#(
    parameter int unsigned N   = FHE_N,
    parameter int unsigned ETA = FHE_ETA,
    parameter int unsigned Q   = FHE_Q,
    parameter int unsigned QW  = FHE_QW
) (
    input  logic                 clk,
    input  logic                 rst,
    cbd_noise_sampler_if.master  bus
);
    localparam int unsigned SPW = slices_per_word(ETA);
    localparam int unsigned SW  = 2 * ETA;
    localparam int unsigned IW  = $clog2(N);
    localparam int unsigned KW  = (SPW > 1) ? $clog2(SPW) : 1;

    cbd_state_e    state;
    logic [15:0]   word;
    logic [KW-1:0] slice_cnt;
    logic [IW-1:0] idx;
    logic          rng_ready;
    logic          coef_valid;
    logic          coef_last;
    logic          busy;
    logic          done;
    logic [SW-1:0] cur_slice;
    logic [QW-1:0] coef_c;

    // Lowest slice of the latched word is consumed first.
    assign cur_slice = SW'(word >> (SW * 32'(slice_cnt)));

    cbd_map #(
        .ETA (ETA),
        .Q   (Q),
        .QW  (QW)
    ) u_cbd_map (
        .slice (cur_slice),
        .coef  (coef_c)
    );

    assign bus.rng_ready  = rng_ready;
    assign bus.coef_valid = coef_valid;
    assign bus.coef       = coef_c;
    assign bus.coef_idx   = idx;
    assign bus.coef_last  = coef_last;
    assign bus.busy       = busy;
    assign bus.done       = done;

    // Sampler FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word       <= '0;
            slice_cnt  <= '0;
            idx        <= '0;
            rng_ready  <= 1'b0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= FETCH;
                        idx       <= '0;
                        slice_cnt <= '0;
                        rng_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.rng_valid && rng_ready) begin
                        state      <= EMIT;
                        word       <= bus.rng_word;
                        slice_cnt  <= '0;
                        rng_ready  <= 1'b0;
                        coef_valid <= 1'b1;
                        coef_last  <= (idx == IW'(N - 1));
                    end
                end
                EMIT: begin
                    if (coef_valid && bus.coef_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == IW'(N - 1)) begin
                            state      <= FIN;
                            coef_valid <= 1'b0;
                            coef_last  <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (slice_cnt == KW'(SPW - 1)) begin
                            // Word exhausted: fetch a fresh one before the next coefficient.
                            state      <= FETCH;
                            coef_valid <= 1'b0;
                            coef_last  <= 1'b0;
                            rng_ready  <= 1'b1;
                        end else begin
                            slice_cnt <= slice_cnt + 1'b1;
                            coef_last <= (idx == IW'(N - 2));
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cbd_noise_sampler.sv
// Self-checking bench for cbd_noise_sampler against a behavioural polynomial model.
module tb_cbd_noise_sampler;

    localparam int unsigned N   = 8;
    localparam int unsigned ETA = 2;
    localparam int unsigned Q   = 7681;
    localparam int unsigned QW  = 13;
    localparam int unsigned IW  = 3;
    localparam int unsigned SPW = 16 / (2 * ETA);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbd_noise_sampler_if #(.QW(QW), .IW(IW)) bus ();

    cbd_noise_sampler #(
        .N   (N),
        .ETA (ETA),
        .Q   (Q),
        .QW  (QW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CBD value of slice k of word w, straight from the definition.
    function automatic int unsigned ref_coef(input logic [15:0] w, input int k);
        int a;
        int b;
        int unsigned lo;
        int unsigned hi;
        lo = (32'(w) >> (2 * ETA * k)) & ((1 << ETA) - 1);
        hi = (32'(w) >> (2 * ETA * k + ETA)) & ((1 << ETA) - 1);
        a = $countones(lo);
        b = $countones(hi);
        return (a >= b) ? 32'(a - b) : Q - 32'(b - a);
    endfunction

    // Stimulus knobs: valid_mode 0=always 1=random 2=low; ready_mode 0=always 1=random 2=1,0,0 pattern.
    int          valid_mode = 0;
    int          ready_mode = 0;
    logic [15:0] supply[$];
    bit          took_word = 1'b0;
    int          cyc = 0;

    // Upstream PRNG and downstream sink behaviour.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (took_word) begin
            took_word = 1'b0;
            bus.rng_word = (supply.size() > 0) ? supply.pop_front() : 16'($urandom);
        end
        case (valid_mode)
            0:       bus.rng_valid = 1'b1;
            1:       bus.rng_valid = ($urandom_range(0, 3) != 0);
            default: bus.rng_valid = 1'b0;
        endcase
        case (ready_mode)
            0:       bus.coef_ready = 1'b1;
            1:       bus.coef_ready = ($urandom_range(0, 2) != 0);
            default: bus.coef_ready = ((cyc % 3) == 0);
        endcase
    end

    // Reference model state: one polynomial in progress, words it consumed, next expected index.
    bit          running = 1'b0;
    bit          fin_now = 1'b0;
    int          exp_idx = 0;
    logic [15:0] mwords[$];
    bit          zero_chk = 1'b0;
    bit          stall_prev = 1'b0;
    logic [QW-1:0] p_coef;
    logic [IW-1:0] p_idx;
    logic          p_last;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    int          got[$];

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit exp_ready;
        bit exp_valid;
        bit idle;
        bit fin_next;
        int nf;
        nf        = mwords.size() * SPW;
        exp_ready = running && (exp_idx == nf);
        exp_valid = running && (exp_idx < nf);
        if (bus.done === 1'b1) done_cnt++;

        check("busy", bus.busy, running);
        check("done", bus.done, fin_now);
        check("rng_ready", bus.rng_ready, exp_ready);
        check("coef_valid", bus.coef_valid, exp_valid);
        if (exp_valid) begin
            check("coef", bus.coef, ref_coef(mwords[exp_idx / SPW], exp_idx % SPW));
            check("coef_idx", bus.coef_idx, exp_idx);
            check("coef_last", bus.coef_last, (exp_idx == N - 1));
        end
        if (stall_prev) begin
            check("stall_coef", bus.coef, p_coef);
            check("stall_idx", bus.coef_idx, p_idx);
            check("stall_last", bus.coef_last, p_last);
        end
        if (zero_chk) begin
            check("rst_coef", bus.coef, 0);
            check("rst_idx", bus.coef_idx, 0);
            check("rst_last", bus.coef_last, 0);
        end

        if (rst) begin
            running    = 1'b0;
            fin_now    = 1'b0;
            exp_idx    = 0;
            mwords.delete();
            zero_chk   = 1'b1;
            stall_prev = 1'b0;
        end else begin
            zero_chk = 1'b0;
            fin_next = 1'b0;
            idle     = !running && !fin_now;
            if (exp_ready && bus.rng_valid) begin
                mwords.push_back(bus.rng_word);
                hs_cnt++;
                took_word = 1'b1;
            end
            if (exp_valid && bus.coef_ready) begin
                got.push_back(int'(bus.coef));
                if (exp_idx == N - 1) begin
                    running  = 1'b0;
                    fin_next = 1'b1;
                end
                exp_idx++;
            end
            stall_prev = exp_valid && !bus.coef_ready;
            p_coef     = bus.coef;
            p_idx      = bus.coef_idx;
            p_last     = bus.coef_last;
            if (idle && bus.start) begin
                running = 1'b1;
                exp_idx = 0;
                mwords.delete();
            end
            fin_now = fin_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1);
        supply.delete();
        supply.push_back(w0);
        supply.push_back(w1);
        took_word = 1'b1;
        got.delete();
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("done_within_budget", bus.done, 1);
    endtask

    task automatic wait_idx(input int target, input int budget);
        int k;
        k = 0;
        while (!(bus.coef_valid === 1'b1 && bus.coef_idx == IW'(target)) && k < budget) begin
            tick();
            k++;
        end
        check("reach_idx", bus.coef_idx, target);
    endtask

    task automatic check_seq1(input string tag);
        int unsigned exp1[8];
        exp1 = '{7680, 2, 1, 1, 0, 0, 0, 0};
        check({tag, "_count"}, got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) check({tag, "_coef"}, got[i], exp1[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
        $fatal(1);
    end

    initial begin
        bus.start      = 1'b0;
        bus.rng_valid  = 1'b0;
        bus.rng_word   = 16'h0000;
        bus.coef_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_busy", bus.busy, 0);
        check("reset_coef_valid", bus.coef_valid, 0);
        check("reset_rng_ready", bus.rng_ready, 0);
        rst = 1'b0;
        tick();

        // Basic polynomial from 0x1234, 0x0000.
        load_words(16'h1234, 16'h0000);
        pulse_start();
        wait_done(100);
        repeat (3) tick();
        check_seq1("t1");
        check("t1_rng_handshakes", hs_cnt, 2);
        check("t1_done_pulses", done_cnt, 1);

        // Negative extreme and positive extreme at index 0.
        load_words(16'h000C, 16'hFFFF);
        pulse_start();
        wait_done(100);
        repeat (2) tick();
        if (got.size() > 0) check("t2_neg2", got[0], 7679);
        for (int i = 1; i < 8; i++) begin
            if (i < got.size()) check("t2_zero", got[i], 0);
        end
        load_words(16'h0003, 16'h0000);
        pulse_start();
        wait_done(100);
        repeat (2) tick();
        if (got.size() > 0) check("t2_pos2", got[0], 2);

        // Backpressure pattern.
        @(negedge clk);
        ready_mode = 2;
        load_words(16'h1234, 16'h0000);
        tick();
        pulse_start();
        wait_done(200);
        repeat (3) tick();
        check_seq1("t3");
        check("t3_done_pulses", done_cnt, 1);
        @(negedge clk);
        ready_mode = 0;

        // Upstream starvation in FETCH.
        valid_mode = 2;
        load_words(16'h1234, 16'h0000);
        tick();
        tick();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t4_rng_ready", bus.rng_ready, 1);
            check("t4_coef_valid", bus.coef_valid, 0);
            tick();
        end
        @(negedge clk);
        valid_mode = 0;
        tick();
        check("t4_not_yet", bus.coef_valid, 0);
        tick();
        check("t4_first_valid", bus.coef_valid, 1);
        check("t4_first_coef", bus.coef, 7680);
        wait_done(100);
        repeat (2) tick();
        check_seq1("t4");

        // start during EMIT and in FIN is ignored.
        load_words(16'h1234, 16'h0000);
        pulse_start();
        wait_idx(3, 50);
        pulse_start();
        wait_done(100);
        pulse_start();
        repeat (6) tick();
        check_seq1("t5");
        check("t5_done_pulses", done_cnt, 1);
        check("t5_idle", bus.busy, 0);

        // Reset mid-polynomial, then a clean run.
        load_words(16'h5A5A, 16'hA5A5);
        pulse_start();
        wait_idx(5, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_coef_valid", bus.coef_valid, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_idx", bus.coef_idx, 0);
        check("t6_coef", bus.coef, 0);
        check("t6_done", bus.done, 0);
        load_words(16'h0003, 16'h0000);
        tick();
        pulse_start();
        wait_done(100);
        repeat (2) tick();
        if (got.size() > 0) check("t6_fresh_coef", got[0], 2);
        check("t6_count", got.size(), 8);
        check("t6_done_pulses", done_cnt, 1);

        // Randomised traffic, start spam and occasional aborts.
        @(negedge clk);
        valid_mode = 1;
        ready_mode = 1;
        supply.delete();
        for (int r = 0; r < 30; r++) begin
            int  k;
            bit  finished;
            bit  aborted;
            k        = 0;
            finished = 1'b0;
            aborted  = 1'b0;
            pulse_start();
            while (!finished && !aborted && k < 400) begin
                bus.start = ($urandom_range(0, 4) == 0);
                tick();
                k++;
                if (bus.done === 1'b1) finished = 1'b1;
                if (!finished && (r % 5 == 4) && bus.coef_valid === 1'b1 && $urandom_range(0, 9) == 0) begin
                    bus.start = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    aborted = 1'b1;
                end
            end
            bus.start = 1'b0;
            check("rand_run_ended", finished || aborted, 1);
            repeat (2) tick();
        end

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cbd_noise_sampler.md
Name: cbd_noise_sampler

Overview:
- Consumer stage directly downstream of the 16-bit PRNG in the FHE encryption path.
- Takes 16-bit random words over a valid/ready handshake and turns them into centered-binomial (CBD) error coefficients, already reduced mod Q.
- Streams one polynomial of N coefficients, with index, to the polynomial buffer/NTT input, then pulses done.

Parameters:
- N, 256, coefficients per polynomial; power of 2; must be a multiple of 16/(2*ETA).
- ETA, 2, CBD parameter; legal values 1, 2, 4 (2*ETA bits per coefficient, so 2*ETA divides 16).
- Q, 7681, coefficient modulus; must satisfy Q > 2*ETA and Q < 2^QW.
- QW, 13, coefficient width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one polynomial; sampled only in IDLE
- rng_valid  in  1  upstream random word available
- rng_word  in  16  upstream random word
- rng_ready  out  1  sampler accepts rng_word this cycle
- coef_valid  out  1  coefficient output valid
- coef_ready  in  1  downstream accepts coefficient
- coef  out  QW  coefficient in [0, Q-1]
- coef_idx  out  clog2(N)  index of current coefficient
- coef_last  out  1  high with coefficient N-1
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last coefficient is accepted

Behaviour:
- Reset: state IDLE; rng_ready, coef_valid, coef, coef_idx, coef_last, busy, done all 0; word register and counters 0.
- FSM states: IDLE, FETCH, EMIT, FIN.
- IDLE:
  - start=1 -> FETCH; clear coefficient counter and slice counter.
  - start=0 -> stay.
- FETCH:
  - rng_ready=1.
  - On rng_valid && rng_ready: latch rng_word into the word register, slice counter=0, go to EMIT.
  - No word is consumed in any other state.
- EMIT:
  - coef_valid=1. Current slice s = word[2*ETA*k +: 2*ETA], where k is the slice counter; the lowest bits are used first.
  - a = popcount(s[ETA-1:0]); b = popcount(s[2*ETA-1:ETA]); d = a - b, in range [-ETA, ETA].
  - coef = d if d >= 0, else Q + d. This is pure combinational from registered state.
  - coef, coef_idx and coef_last hold stable while coef_valid && !coef_ready.
  - On coef_valid && coef_ready:
    - coef_idx == N-1 -> FIN.
    - Else if k == 16/(2*ETA)-1 -> FETCH.
    - Else k+1, stay in EMIT.
    - In every case coef_idx increments.
- FIN: done=1 for exactly one cycle, then IDLE. busy=0 in the FIN cycle.
- Throughput: one coefficient per cycle under no backpressure. Each word fetch costs at least 1 cycle, so with rng_valid tied high the ETA=2 rate is 4 coefficients per 5 cycles.
- Latency: start to first coef_valid is 2 cycles minimum (IDLE->FETCH, then FETCH->EMIT on handshake).
- Words consumed per polynomial: exactly N*2*ETA/16. A partially used word is never carried across polynomials.
- start while busy: ignored.
- start in the FIN cycle: ignored. start in IDLE the following cycle is honoured.
- rng_valid while not in FETCH: ignored; rng_ready is 0.
- Reset mid-operation: aborts immediately to the reset state. No done pulse is produced and no partial word is retained.
- coef_ready low indefinitely: the block stalls in EMIT with no loss or duplication of coefficients.

Decomposition:
- Shared package fhe_pkg:
  - Q, QW and N defaults.
  - ETA.
  - Derived constant SLICES_PER_WORD = 16/(2*ETA).
  - FSM state encoding typedef.
- Sub-module cbd_map (combinational):
  - Input: a 2*ETA-bit slice.
  - Output: the QW-bit coefficient mod Q, computed by popcount difference plus conditional add of Q.
  - Instantiated once.

Test Plan:
1. Configuration N=8, ETA=2, Q=7681. Words 0x1234 then 0x0000, rng_valid always 1, coef_ready always 1 -> coefs 7680, 2, 1, 1, 0, 0, 0, 0.
   - coef_idx runs 0..7.
   - coef_last high only at index 7.
   - Exactly 2 rng handshakes.
   - done pulses 1 cycle after the index-7 accept.
2. Words 0x000C then 0xFFFF -> coef 7679 (d=-2) at idx 0, then 0 for the rest. Word 0x0003 -> coef 2 at idx 0.
3. Backpressure: coef_ready toggles 1,0,0,1,... during test 1 -> identical coefficient sequence. coef, coef_idx and coef_last remain stable across every stall cycle.
4. Upstream starvation: rng_valid held low for 5 cycles in FETCH -> rng_ready stays 1, coef_valid stays 0, no state change. The first coefficient appears the cycle after rng_valid rises.
5. start pulsed at idx 3 and in the FIN cycle -> both ignored; exactly 8 coefficients and 1 done pulse.
6. rst asserted at idx 5 -> next cycle shows all outputs 0 and state IDLE. A new start gives a fresh idx 0 from a newly fetched word, and done fires only for the completed run.
